piso_tx_sched: RTL

PISO_TX_SCHED -- requirements
Module: piso_tx_sched

---
 rtl/piso_pkg.sv | 21 ++
 rtl/piso_tx_sched_rr_arb.sv | 36 +++
 rtl/piso_tx_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO transmit scheduler.
// The PAR state exists only when PISO_PARITY_EN is defined.
package piso_pkg;

    localparam int PISO_W = 4;
    localparam int CNT_W  = $clog2(PISO_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
`ifdef PISO_PARITY_EN
        ,
        ST_PAR   = 2'd2
`endif
    } state_t;

    function automatic logic piso_parity(input logic [PISO_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/piso_tx_sched_rr_arb.sv
// Round-robin arbiter: picks the first active request at or after ptr,
// wrapping modulo NREQ, and returns it as one-hot plus binary index.
module rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    int j;

    // Walk the search order backwards so the candidate nearest ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j]) begin
                gnt     = '0;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/piso_tx_sched.sv
// Multi-requester nibble serializer with round-robin grant, LSB first.
// Optional even-parity trailer bit enabled by macro PISO_PARITY_EN.
module piso_tx_sched #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        data,
    output logic [NREQ-1:0]          ack,
    output logic                     out,
    output logic                     out_vld,
    output logic                     sof,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy
);

    import piso_pkg::*;

    localparam int IW = $clog2(NREQ);

    state_t             state_q, state_d;
    logic [W-1:0]       sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic               out_q, out_d;
    logic               vld_q, vld_d;
    logic               sof_q, sof_d;
    logic               grant_slot;

    logic [W-1:0]       nib [NREQ];
    logic [NREQ-1:0]    gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_vld;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_nib
            assign nib[gi] = data[gi*W +: W];
        end
    endgenerate

    rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        out_d      = out_q;
        vld_d      = vld_q;
        sof_d      = sof_q;
        ack        = '0;
        grant_slot = 1'b0;

        if (enable && !rst) begin
            case (state_q)
                ST_IDLE: begin
                    grant_slot = 1'b1;
                end
                ST_SHIFT: begin
                    sof_d = 1'b0;
                    if (cnt_q == CNT_W'(W - 1)) begin
`ifdef PISO_PARITY_EN
                        state_d = ST_PAR;
                        out_d   = piso_parity(sh_q);
`else
                        grant_slot = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        out_d = sh_q[cnt_q + 1'b1];
                    end
                end
`ifdef PISO_PARITY_EN
                ST_PAR: begin
                    grant_slot = 1'b1;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // The last frame cycle doubles as the next grant cycle, so frames abut.
            if (grant_slot) begin
                if (gnt_vld) begin
                    ack     = gnt;
                    state_d = ST_SHIFT;
                    sh_d    = nib[gnt_idx];
                    cnt_d   = '0;
                    out_d   = nib[gnt_idx][0];
                    vld_d   = 1'b1;
                    sof_d   = 1'b1;
                    owner_d = gnt_idx;
                    ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    out_d   = 1'b0;
                    vld_d   = 1'b0;
                    sof_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
        end
    end

    assign out     = out_q;
    assign out_vld = vld_q;
    assign sof     = sof_q;
    assign owner   = owner_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
